dma_bus_arbiter: RTL and testbench

Multi-channel bus arbiter and command front end between the CPU data-memory port and up to NUM_CH DMA engines. It grants the shared memory bus to one requesting DMA channel at a time, round-robin. A grant is issued only when the CPU's data-memory access is not mid-transaction. It also registers each channel's start interrupt into a command strobe and latches end interrupts into sticky, software-acknowledged status bits.

---
 rtl/dma_bus_arbiter_if.sv | 32 +++
 rtl/dma_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_dma_bus_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dma_bus_arbiter_if.sv
// Shared-bus arbitration signals between the DMA engines (master) and the
// round-robin arbiter (slave).
interface dma_bus_arbiter_if #(
   parameter int NUM_CH = 2
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // Handshake: a channel holds BR[i] high (level) until it is done with the
   // bus; BG[i] is the registered answer. The owner keeps the bus for as long
   // as its BR stays high and releases it by dropping BR. yield_req is advisory.
   logic [NUM_CH-1:0] BR;
   logic [NUM_CH-1:0] BG;
   logic [CH_W-1:0]   grant_id;
   logic              bus_owned;
   logic              yield_req;

   modport master (
      output BR,
      input  BG,
      input  grant_id,
      input  bus_owned,
      input  yield_req
   );

   modport slave (
      input  BR,
      output BG,
      output grant_id,
      output bus_owned,
      output yield_req
   );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Round-robin arbiter handing the shared memory bus to DMA channels while the
// CPU data port is idle, plus start-command and sticky end-status registers.
module dma_bus_arbiter #(
   parameter int       NUM_CH     = 2,
   parameter int       WORD_SIZE  = 16,
   parameter logic [3:0] NOP_OPCODE = 4'hf,
   parameter int       MAX_HOLD   = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   dma_bus_arbiter_if.slave       bus,
   input  logic [NUM_CH-1:0]      dma_start_int,
   output logic [NUM_CH-1:0]      cmd,
   input  logic [NUM_CH-1:0]      dma_end_int,
   input  logic [NUM_CH-1:0]      end_ack,
   output logic [NUM_CH-1:0]      end_status,
   input  logic                   d_readM,
   input  logic                   d_writeM,
   input  logic [4*WORD_SIZE-1:0] d_data,
   input  logic                   doneWrite_d,
   output logic                   dbg_state
);

   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [NUM_CH-1:0] bg_q, bg_nxt;
   logic [CH_W-1:0]   gid_q, gid_nxt;
   logic              owned_q, owned_nxt;
   logic [CH_W-1:0]   last_q, last_nxt;
   logic [HOLD_W-1:0] hold_q, hold_nxt;
   logic [CH_W-1:0]   sel;
   logic              sel_found;
   logic              mem_busy;
   logic [NUM_CH-1:0] others;
   logic              unused_data;

   // Only the opcode nibble of the read line matters here.
   assign unused_data = ^d_data[4*WORD_SIZE-5:0];

   assign mem_busy = (d_readM && (d_data[4*WORD_SIZE-1 -: 4] == NOP_OPCODE)) ||
                     (d_writeM && !doneWrite_d);

   // First requester at or after last_owner+1, wrapping.
   always_comb begin
      logic [CH_W-1:0] idx;
      idx       = '0;
      sel       = '0;
      sel_found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = CH_W'((int'(last_q) + 1 + i) % NUM_CH);
         if (!sel_found && bus.BR[idx]) begin
            sel       = idx;
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      bg_nxt    = bg_q;
      gid_nxt   = gid_q;
      owned_nxt = owned_q;
      last_nxt  = last_q;
      hold_nxt  = hold_q;
      case (state)
         IDLE: begin
            hold_nxt  = '0;
            bg_nxt    = '0;
            owned_nxt = 1'b0;
            if (sel_found && !mem_busy) begin
               bg_nxt[sel] = 1'b1;
               gid_nxt     = sel;
               owned_nxt   = 1'b1;
               state_nxt   = GRANT;
            end
         end
         GRANT: begin
            if (bus.BR[gid_q]) begin
               if (hold_q != HOLD_MAX) hold_nxt = hold_q + 1'b1;
            end else begin
               // Release edge never re-grants, leaving one bus-free cycle.
               bg_nxt    = '0;
               owned_nxt = 1'b0;
               last_nxt  = gid_q;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         bg_q    <= '0;
         gid_q   <= '0;
         owned_q <= 1'b0;
         last_q  <= LAST_CH;
         hold_q  <= '0;
      end else begin
         state   <= state_nxt;
         bg_q    <= bg_nxt;
         gid_q   <= gid_nxt;
         owned_q <= owned_nxt;
         last_q  <= last_nxt;
         hold_q  <= hold_nxt;
      end
   end

   assign others = bus.BR & ~bg_q;

   assign bus.BG        = bg_q;
   assign bus.grant_id  = gid_q;
   assign bus.bus_owned = owned_q;
   assign bus.yield_req = (state == GRANT) && (MAX_HOLD > 0) &&
                          (hold_q == HOLD_MAX) && (|others);
   assign dbg_state     = state;

   // Set has priority over acknowledge so no end event is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd        <= '0;
         end_status <= '0;
      end else begin
         cmd        <= dma_start_int;
         end_status <= (end_status & ~end_ack) | dma_end_int;
      end
   end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench: a 2-channel arbiter for the main paths and a 4-channel,
// MAX_HOLD=4 instance for yield_req and wrap-around selection.
module tb_dma_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  dma_start_int, dma_end_int, end_ack;
   logic [1:0]  cmd, end_status;
   logic        d_readM, d_writeM, doneWrite_d;
   logic [63:0] d_data;
   logic        dbg_state;
   logic [3:0]  b_cmd, b_end_status;
   logic        b_dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   dma_bus_arbiter_if #(.NUM_CH(2)) bus_a ();
   dma_bus_arbiter_if #(.NUM_CH(4)) bus_b ();

   dma_bus_arbiter #(.NUM_CH(2), .WORD_SIZE(16), .NOP_OPCODE(4'hf), .MAX_HOLD(0)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(bus_a),
      .dma_start_int(dma_start_int), .cmd(cmd),
      .dma_end_int(dma_end_int), .end_ack(end_ack), .end_status(end_status),
      .d_readM(d_readM), .d_writeM(d_writeM), .d_data(d_data),
      .doneWrite_d(doneWrite_d), .dbg_state(dbg_state)
   );

   dma_bus_arbiter #(.NUM_CH(4), .WORD_SIZE(16), .NOP_OPCODE(4'hf), .MAX_HOLD(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .bus(bus_b),
      .dma_start_int(4'b0), .cmd(b_cmd),
      .dma_end_int(4'b0), .end_ack(4'b0), .end_status(b_end_status),
      .d_readM(1'b0), .d_writeM(1'b0), .d_data(64'h0),
      .doneWrite_d(1'b0), .dbg_state(b_dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      bus_a.BR      = '0;
      bus_b.BR      = '0;
      dma_start_int = '0;
      dma_end_int   = '0;
      end_ack       = '0;
      d_readM       = 1'b0;
      d_writeM      = 1'b0;
      doneWrite_d   = 1'b0;
      d_data        = '0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      bus_a.BR = 2'b01;
      tick();
      reset_n = 1'b0;
      tick();
      vectors++; if (bus_a.BG !== 2'b00) begin miscompares++; $display("FAIL reset_bg got=%b exp=00", bus_a.BG); end
      vectors++; if (bus_a.bus_owned !== 1'b0) begin miscompares++; $display("FAIL reset_owned got=%b exp=0", bus_a.bus_owned); end
      vectors++; if (bus_a.grant_id !== 1'b0) begin miscompares++; $display("FAIL reset_gid got=%b exp=0", bus_a.grant_id); end
      vectors++; if (bus_a.yield_req !== 1'b0) begin miscompares++; $display("FAIL reset_yield got=%b exp=0", bus_a.yield_req); end
      vectors++; if ({cmd, end_status} !== 4'b0000) begin miscompares++; $display("FAIL reset_cmd_status got=%b exp=0000", {cmd, end_status}); end
      vectors++; if (dbg_state !== 1'b0) begin miscompares++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
      vectors++; if (bus_b.BG !== 4'b0000) begin miscompares++; $display("FAIL reset_bg4 got=%b exp=0000", bus_b.BG); end
   endtask

   task automatic test_basic_grant();
      do_reset();
      bus_a.BR = 2'b01;
      tick();
      vectors++; if (bus_a.BG !== 2'b01) begin miscompares++; $display("FAIL grant_bg got=%b exp=01", bus_a.BG); end
      vectors++; if (bus_a.grant_id !== 1'b0) begin miscompares++; $display("FAIL grant_gid got=%b exp=0", bus_a.grant_id); end
      vectors++; if (bus_a.bus_owned !== 1'b1) begin miscompares++; $display("FAIL grant_owned got=%b exp=1", bus_a.bus_owned); end
      bus_a.BR = 2'b00;
      tick();
      vectors++; if (bus_a.BG !== 2'b00) begin miscompares++; $display("FAIL release_bg got=%b exp=00", bus_a.BG); end
      vectors++; if (bus_a.bus_owned !== 1'b0) begin miscompares++; $display("FAIL release_owned got=%b exp=0", bus_a.bus_owned); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_bg [3];
      exp_bg[0] = 2'b01;
      exp_bg[1] = 2'b10;
      exp_bg[2] = 2'b01;
      do_reset();
      bus_a.BR = 2'b11;
      for (int g = 0; g < 3; g++) begin
         for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (bus_a.BG !== exp_bg[g]) begin miscompares++; $display("FAIL rr_hold g=%0d c=%0d got=%b exp=%b", g, c, bus_a.BG, exp_bg[g]); end
         end
         vectors++; if (bus_a.grant_id !== ((exp_bg[g] == 2'b10) ? 1'b1 : 1'b0)) begin miscompares++; $display("FAIL rr_gid g=%0d got=%b", g, bus_a.grant_id); end
         bus_a.BR = ~exp_bg[g];
         tick();
         vectors++; if (bus_a.BG !== 2'b00) begin miscompares++; $display("FAIL rr_gap g=%0d got=%b exp=00", g, bus_a.BG); end
         bus_a.BR = 2'b11;
      end
      bus_a.BR = 2'b00;
      tick();
      tick();
   endtask

   task automatic test_read_busy();
      do_reset();
      d_readM  = 1'b1;
      d_data   = {4'hf, 60'h123};
      bus_a.BR = 2'b01;
      for (int c = 0; c < 5; c++) begin
         tick();
         vectors++; if (bus_a.BG !== 2'b00) begin miscompares++; $display("FAIL rd_busy c=%0d got=%b exp=00", c, bus_a.BG); end
      end
      d_data = {4'h0, 60'h123};
      tick();
      vectors++; if (bus_a.BG !== 2'b01) begin miscompares++; $display("FAIL rd_free got=%b exp=01", bus_a.BG); end
   endtask

   task automatic test_write_busy();
      do_reset();
      d_writeM = 1'b1;
      bus_a.BR = 2'b01;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++; if (bus_a.BG !== 2'b00) begin miscompares++; $display("FAIL wr_busy c=%0d got=%b exp=00", c, bus_a.BG); end
      end
      doneWrite_d = 1'b1;
      tick();
      vectors++; if (bus_a.BG !== 2'b01) begin miscompares++; $display("FAIL wr_done got=%b exp=01", bus_a.BG); end
      doneWrite_d = 1'b0;
      d_readM     = 1'b1;
      d_data      = {4'hf, 60'h0};
      bus_a.BR    = 2'b11;
      for (int c = 0; c < 2; c++) begin
         tick();
         vectors++; if (bus_a.BG !== 2'b01) begin miscompares++; $display("FAIL wr_midgrant c=%0d got=%b exp=01", c, bus_a.BG); end
      end
   endtask

   task automatic test_yield();
      do_reset();
      bus_b.BR = 4'b0100;
      tick();
      vectors++; if (bus_b.BG !== 4'b0100) begin miscompares++; $display("FAIL y_grant got=%b exp=0100", bus_b.BG); end
      vectors++; if (bus_b.grant_id !== 2'd2) begin miscompares++; $display("FAIL y_gid got=%0d exp=2", bus_b.grant_id); end
      bus_b.BR = 4'b0101;
      for (int c = 1; c <= 4; c++) begin
         tick();
         vectors++; if (bus_b.yield_req !== (c == 4)) begin miscompares++; $display("FAIL y_count c=%0d got=%b exp=%b", c, bus_b.yield_req, (c == 4)); end
      end
      bus_b.BR = 4'b0100;
      #1;
      vectors++; if (bus_b.yield_req !== 1'b0) begin miscompares++; $display("FAIL y_noother got=%b exp=0", bus_b.yield_req); end
      bus_b.BR = 4'b0101;
      #1;
      vectors++; if (bus_b.yield_req !== 1'b1) begin miscompares++; $display("FAIL y_again got=%b exp=1", bus_b.yield_req); end
      bus_b.BR = 4'b0001;
      tick();
      vectors++; if ({bus_b.BG, bus_b.yield_req} !== 5'b0000_0) begin miscompares++; $display("FAIL y_release got=%b exp=00000", {bus_b.BG, bus_b.yield_req}); end
      tick();
      vectors++; if (bus_b.BG !== 4'b0001) begin miscompares++; $display("FAIL y_wrap got=%b exp=0001", bus_b.BG); end
      vectors++; if (bus_b.grant_id !== 2'd0) begin miscompares++; $display("FAIL y_wrap_gid got=%0d exp=0", bus_b.grant_id); end
      vectors++; if (bus_b.yield_req !== 1'b0) begin miscompares++; $display("FAIL y_fresh got=%b exp=0", bus_b.yield_req); end
   endtask

   task automatic test_cmd_status();
      do_reset();
      dma_start_int = 2'b10;
      tick();
      dma_start_int = 2'b00;
      vectors++; if (cmd !== 2'b10) begin miscompares++; $display("FAIL cmd_pulse got=%b exp=10", cmd); end
      tick();
      vectors++; if (cmd !== 2'b00) begin miscompares++; $display("FAIL cmd_clear got=%b exp=00", cmd); end
      dma_end_int = 2'b10;
      end_ack     = 2'b10;
      tick();
      dma_end_int = 2'b00;
      end_ack     = 2'b00;
      vectors++; if (end_status !== 2'b10) begin miscompares++; $display("FAIL st_setwins got=%b exp=10", end_status); end
      tick();
      vectors++; if (end_status !== 2'b10) begin miscompares++; $display("FAIL st_sticky got=%b exp=10", end_status); end
      end_ack     = 2'b10;
      dma_end_int = 2'b01;
      tick();
      end_ack     = 2'b00;
      dma_end_int = 2'b00;
      vectors++; if (end_status !== 2'b01) begin miscompares++; $display("FAIL st_ack got=%b exp=01", end_status); end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus_a.BR = 2'b10;
      tick();
      vectors++; if (bus_a.BG !== 2'b10) begin miscompares++; $display("FAIL ar_grant got=%b exp=10", bus_a.BG); end
      #2;
      reset_n = 1'b0;
      #1;
      vectors++; if ({bus_a.BG, bus_a.bus_owned} !== 3'b000) begin miscompares++; $display("FAIL ar_drop got=%b exp=000", {bus_a.BG, bus_a.bus_owned}); end
      #1;
      reset_n  = 1'b1;
      bus_a.BR = 2'b11;
      tick();
      vectors++; if (bus_a.BG !== 2'b01) begin miscompares++; $display("FAIL ar_restart got=%b exp=01", bus_a.BG); end
   endtask

   initial begin
      test_reset();
      test_basic_grant();
      test_round_robin();
      test_read_busy();
      test_write_busy();
      test_yield();
      test_cmd_status();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
